// File: rtl/quire_to_posit.sv
// Quire-to-posit converter: captures the segmented two's-complement quire on a
// rising acc_rdy, normalizes over several cycles and emits a round-to-nearest-even posit.
module quire_to_posit #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned EXP      = 2,
  parameter int unsigned K        = 9,
  parameter int unsigned ACC      = (2**EXP)*(WIDTH-2),
  parameter int unsigned ACC_HEAD = $clog2(K)+2
) (
  input  logic                clk_i,
  input  logic                rstn,
  input  logic                acc_rdy,
  input  logic [ACC_HEAD-1:0] acc_000_c,
  input  logic [ACC-1:0]      acc_001_c,
  input  logic [ACC-1:0]      acc_010_c,
  input  logic [ACC-1:0]      acc_011_c,
  input  logic [ACC-1:0]      acc_100_c,
  input  logic                out_rdy,
  output logic                out_vld,
  output logic [WIDTH-1:0]    posit_o,
  output logic                busy,
  output logic                drop_o
);

  localparam int unsigned QW   = ACC_HEAD + 4*ACC;
  localparam int unsigned FRAC = 2*ACC;
  localparam int unsigned MAXS = (2**EXP)*(WIDTH-2);
  localparam int unsigned FW   = WIDTH;
  localparam int unsigned VW   = WIDTH + EXP + FW;
  localparam int unsigned SW   = $clog2(QW) + 2;
  localparam int unsigned LW   = $clog2(ACC);
  localparam logic [WIDTH-2:0] MAXPOS = '1;
  localparam logic [WIDTH-2:0] MINPOS = (WIDTH-1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_NEG, S_SCAN, S_NORM, S_PACK, S_OUT} state_e;

  state_e               state_q, state_d;
  logic                 acc_rdy_q, acc_rdy_d;
  logic [QW-1:0]        q_reg_q, q_reg_d;
  logic                 sign_q, sign_d;
  logic                 zero_q, zero_d;
  logic [2:0]           seg_q, seg_d;
  logic signed [SW-1:0] scale_q, scale_d;
  logic [FW-1:0]        frac_q, frac_d;
  logic                 sticky_q, sticky_d;
  logic                 out_vld_q, out_vld_d;
  logic [WIDTH-1:0]     posit_q, posit_d;
  logic                 drop_q, drop_d;

  logic                 start;
  logic [ACC-1:0]       seg_val;
  logic [LW-1:0]        lod_idx;
  int                   p_int;
  logic [QW-2:0]        shifted;
  logic signed [SW-1:0] k;
  logic [SW-1:0]        rshift;
  logic [VW-1:0]        base_pos, base_neg, v;
  logic [WIDTH-2:0]     body, mag_p;
  logic                 guard, sticky_all;
  logic [WIDTH-1:0]     rnd;

  assign start = acc_rdy & ~acc_rdy_q;

  // Segment under inspection; the head is zero-extended to body width.
  always_comb begin
    seg_val = '0;
    case (seg_q)
      3'd0:    seg_val[ACC_HEAD-1:0] = q_reg_q[QW-1 -: ACC_HEAD];
      3'd1:    seg_val = q_reg_q[4*ACC-1 -: ACC];
      3'd2:    seg_val = q_reg_q[3*ACC-1 -: ACC];
      3'd3:    seg_val = q_reg_q[2*ACC-1 -: ACC];
      default: seg_val = q_reg_q[ACC-1:0];
    endcase
    lod_idx = '0;
    for (int unsigned i = 0; i < ACC; i++) begin
      if (seg_val[i]) lod_idx = LW'(i);
    end
    p_int   = (4 - int'(seg_q)) * int'(ACC) + int'(lod_idx);
    // The leading one shifts out of the top, leaving the fraction left-aligned.
    shifted = q_reg_q[QW-2:0] << (int'(QW) - 1 - p_int);
  end

  // Regime run is produced by shifting a "10"/"01" seed: arithmetic shift
  // replicates ones for k >= 0, logical shift inserts zeros for k < 0.
  always_comb begin
    k        = scale_q >>> EXP;
    rshift   = k[SW-1] ? SW'(-k - 1) : SW'(k);
    base_pos = {2'b10, scale_q[EXP-1:0], frac_q, {(VW-2-EXP-FW){1'b0}}};
    base_neg = {2'b01, scale_q[EXP-1:0], frac_q, {(VW-2-EXP-FW){1'b0}}};
    if (k[SW-1]) v = base_neg >> rshift;
    else         v = VW'($signed(base_pos) >>> rshift);
    body       = v[VW-1 -: WIDTH-1];
    guard      = v[VW-WIDTH];
    sticky_all = (|v[VW-WIDTH-1:0]) | sticky_q;
    rnd        = {1'b0, body} + WIDTH'(guard & (sticky_all | body[0]));
    mag_p      = rnd[WIDTH-1] ? MAXPOS : rnd[WIDTH-2:0];
    if (zero_q)                                  mag_p = '0;
    else if (int'(scale_q) >= int'(MAXS))        mag_p = MAXPOS;
    else if (int'(scale_q) < -int'(MAXS))        mag_p = MINPOS;
  end

  always_comb begin
    state_d   = state_q;
    acc_rdy_d = acc_rdy;
    q_reg_d   = q_reg_q;
    sign_d    = sign_q;
    zero_d    = zero_q;
    seg_d     = seg_q;
    scale_d   = scale_q;
    frac_d    = frac_q;
    sticky_d  = sticky_q;
    out_vld_d = out_vld_q;
    posit_d   = posit_q;
    drop_d    = start && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          q_reg_d = {acc_000_c, acc_001_c, acc_010_c, acc_011_c, acc_100_c};
          state_d = S_NEG;
        end
      end
      S_NEG: begin
        sign_d  = q_reg_q[QW-1];
        q_reg_d = q_reg_q[QW-1] ? -q_reg_q : q_reg_q;
        seg_d   = '0;
        zero_d  = 1'b0;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        if (seg_val != '0) begin
          state_d = S_NORM;
        end else if (seg_q == 3'd4) begin
          zero_d  = 1'b1;
          state_d = S_NORM;
        end else begin
          seg_d = seg_q + 3'd1;
        end
      end
      S_NORM: begin
        scale_d  = SW'(p_int - int'(FRAC));
        frac_d   = shifted[QW-2 -: FW];
        sticky_d = |shifted[QW-2-FW:0];
        state_d  = S_PACK;
      end
      S_PACK: begin
        posit_d   = sign_q ? -{1'b0, mag_p} : {1'b0, mag_p};
        out_vld_d = 1'b1;
        state_d   = S_OUT;
      end
      S_OUT: begin
        if (out_rdy) begin
          out_vld_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      acc_rdy_q <= 1'b0;
      q_reg_q   <= '0;
      sign_q    <= 1'b0;
      zero_q    <= 1'b0;
      seg_q     <= '0;
      scale_q   <= '0;
      frac_q    <= '0;
      sticky_q  <= 1'b0;
      out_vld_q <= 1'b0;
      posit_q   <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_rdy_q <= acc_rdy_d;
      q_reg_q   <= q_reg_d;
      sign_q    <= sign_d;
      zero_q    <= zero_d;
      seg_q     <= seg_d;
      scale_q   <= scale_d;
      frac_q    <= frac_d;
      sticky_q  <= sticky_d;
      out_vld_q <= out_vld_d;
      posit_q   <= posit_d;
      drop_q    <= drop_d;
    end
  end

  assign out_vld = out_vld_q;
  assign posit_o = posit_q;
  assign busy    = (state_q != S_IDLE);
  assign drop_o  = drop_q;

endmodule

// File: tb/tb_quire_to_posit.sv
// Scoreboard bench for quire_to_posit: directed quire vectors with hand-computed
// posit results; a negedge monitor pops and compares on every presented output.
module tb_quire_to_posit;

  logic        clk_i = 1'b0;
  logic        rstn;
  logic        acc_rdy;
  logic [5:0]  a0;
  logic [23:0] a1, a2, a3, a4;
  logic        out_rdy;
  logic        out_vld;
  logic [7:0]  posit_o;
  logic        busy;
  logic        drop_o;

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] sb[$];

  quire_to_posit #(.WIDTH(8), .EXP(2), .K(9)) dut (
    .clk_i(clk_i), .rstn(rstn), .acc_rdy(acc_rdy),
    .acc_000_c(a0), .acc_001_c(a1), .acc_010_c(a2), .acc_011_c(a3), .acc_100_c(a4),
    .out_rdy(out_rdy), .out_vld(out_vld), .posit_o(posit_o),
    .busy(busy), .drop_o(drop_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Held outputs are compared every cycle against the head entry; popped on handshake.
  always @(negedge clk_i) begin
    if (rstn && out_vld) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_output: got %02h expected none", posit_o);
      end else begin
        check("posit_o", {24'd0, posit_o}, {24'd0, sb[0]});
        if (out_rdy) void'(sb.pop_front());
      end
    end
  end

  task automatic load(input logic [5:0] h, input logic [23:0] s1, s2, s3, s4);
    a0 = h; a1 = s1; a2 = s2; a3 = s3; a4 = s4;
  endtask

  task automatic scramble();
    load(6'($urandom), 24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom));
  endtask

  task automatic wait_vld(input string name, input int exp_lat);
    int cyc = 0;
    while (!out_vld && cyc < 40) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    check({name, "_latency"}, cyc, exp_lat);
  endtask

  task automatic wait_done(input string name, input logic [7:0] exp);
    int cyc = 0;
    while (out_vld && cyc < 40) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    check({name, "_accept"}, cyc, 1);
    check({name, "_retain"}, {24'd0, posit_o}, {24'd0, exp});
  endtask

  task automatic run_vec(input string name, input logic [5:0] h,
                         input logic [23:0] s1, s2, s3, s4,
                         input logic [7:0] exp, input int exp_lat, input int hold);
    @(posedge clk_i); #1;
    load(h, s1, s2, s3, s4);
    acc_rdy = 1'b1;
    out_rdy = (hold == 0);
    sb.push_back(exp);
    @(posedge clk_i); #1;
    acc_rdy = 1'b0;
    scramble();
    wait_vld(name, exp_lat);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_i); #1;
      check({name, "_vld_held"}, {31'd0, out_vld}, 1);
    end
    out_rdy = 1'b1;
    wait_done(name, exp);
  endtask

  initial begin
    int cnt;
    rstn = 1'b0; acc_rdy = 1'b0; out_rdy = 1'b1;
    load('0, '0, '0, '0, '0);
    #12;
    check("rst_out_vld", {31'd0, out_vld}, 0);
    check("rst_posit",   {24'd0, posit_o}, 0);
    check("rst_busy",    {31'd0, busy}, 0);
    check("rst_drop",    {31'd0, drop_o}, 0);

    // acc_rdy already high when reset releases counts as a start edge
    load(6'h00, 24'h0, 24'h000001, 24'h0, 24'h0);
    acc_rdy = 1'b1;
    sb.push_back(8'h40);
    @(negedge clk_i); rstn = 1'b1;
    @(posedge clk_i); #1;
    acc_rdy = 1'b0;
    scramble();
    wait_vld("start_from_reset", 6);
    wait_done("start_from_reset", 8'h40);

    run_vec("one",       6'h00, 24'h0,      24'h000001, 24'h000000, 24'h0,      8'h40, 6, 0);
    run_vec("minus_one", 6'h3F, 24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'h0,      8'hC0, 6, 0);
    run_vec("one_half",  6'h00, 24'h0,      24'h000001, 24'h800000, 24'h0,      8'h44, 6, 0);
    run_vec("tie_even",  6'h00, 24'h0,      24'h000001, 24'h100000, 24'h0,      8'h40, 6, 0);
    run_vec("round_up",  6'h00, 24'h0,      24'h000001, 24'h300000, 24'h0,      8'h42, 6, 0);
    run_vec("four",      6'h00, 24'h0,      24'h000004, 24'h000000, 24'h0,      8'h50, 6, 0);
    run_vec("pow_m5",    6'h00, 24'h0,      24'h000000, 24'h080000, 24'h0,      8'h1C, 7, 0);
    run_vec("pow_23",    6'h00, 24'h0,      24'h800000, 24'h000000, 24'h0,      8'h7F, 6, 0);
    run_vec("pow_m24",   6'h00, 24'h0,      24'h000000, 24'h000001, 24'h0,      8'h01, 7, 0);
    run_vec("pow_30",    6'h00, 24'h000040, 24'h000000, 24'h000000, 24'h0,      8'h7F, 5, 0);
    run_vec("pow_m30",   6'h00, 24'h0,      24'h000000, 24'h000000, 24'h040000, 8'h01, 8, 0);
    run_vec("most_neg",  6'h20, 24'h0,      24'h000000, 24'h000000, 24'h0,      8'h81, 4, 0);
    run_vec("zero",      6'h00, 24'h0,      24'h000000, 24'h000000, 24'h0,      8'h00, 8, 0);
    run_vec("hold_m1p5", 6'h3F, 24'hFFFFFF, 24'hFFFFFE, 24'h800000, 24'h0,      8'hBC, 6, 5);

    // Second start edge while busy is dropped and never produces output
    @(posedge clk_i); #1;
    load(6'h00, 24'h0, 24'h000001, 24'h800000, 24'h0);
    acc_rdy = 1'b1;
    sb.push_back(8'h44);
    @(posedge clk_i); #1;
    acc_rdy = 1'b0;
    @(posedge clk_i); #1;
    load(6'h00, 24'h000040, 24'h0, 24'h0, 24'h0);
    acc_rdy = 1'b1;
    @(posedge clk_i); #1;
    check("drop_pulse", {31'd0, drop_o}, 1);
    acc_rdy = 1'b0;
    @(posedge clk_i); #1;
    check("drop_clear", {31'd0, drop_o}, 0);
    wait_vld("drop", 3);
    wait_done("drop", 8'h44);

    // Reset during SCAN aborts without emitting a result
    @(posedge clk_i); #1;
    load(6'h00, 24'h0, 24'h000001, 24'h0, 24'h0);
    acc_rdy = 1'b1;
    @(posedge clk_i); #1;
    acc_rdy = 1'b0;
    @(posedge clk_i); #1;
    check("busy_in_scan", {31'd0, busy}, 1);
    rstn = 1'b0;
    #1;
    check("rst_mid_busy",    {31'd0, busy}, 0);
    check("rst_mid_out_vld", {31'd0, out_vld}, 0);
    @(posedge clk_i);
    @(negedge clk_i); rstn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_i); #1;
      if (out_vld || busy) cnt++;
    end
    check("no_output_after_abort", cnt, 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
